// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/response bus between the access controller and memory.
// Strobes are one-cycle pulses; mem_done completes an access, mem_busy blocks a new one.
interface mem_access_ctrl_if;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_busy;

    modport master (
        output mem_addr, mem_wdata, mem_rd, mem_wr,
        input  mem_rdata, mem_done, mem_busy
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_rd, mem_wr,
        output mem_rdata, mem_done, mem_busy
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one load/store, stalls the pipeline until done or watchdog expiry.
// Request strobes appear one cycle after acceptance; load data lands in MemOut_ff on the mem_done edge.
module mem_access_ctrl (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               ALU_Out,
    input  logic [15:0]               WrData,
    input  logic                      MemRead_2ff,
    input  logic                      MemWrt_2ff,
    input  logic                      nHaltSig,
    mem_access_ctrl_if.master         mem,
    output logic                      Stall,
    output logic [15:0]               MemOut_ff,
    output logic [15:0]               ALU_Out_ff,
    output logic                      err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  wdog_q;
    logic        err_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        is_load_q;
    logic [15:0] mem_out_q;
    logic [15:0] alu_out_q;

    logic        one_strobe;
    logic        access_vld;
    logic        access_bad;
    logic        load_done;
    logic [15:0] mem_out_d;

    assign one_strobe = MemRead_2ff ^ MemWrt_2ff;
    assign access_vld = one_strobe & nHaltSig & ~ALU_Out[0];
    // Conflicting strobes or a misaligned address degrade to a non-memory op with err raised.
    assign access_bad = nHaltSig & ((MemRead_2ff & MemWrt_2ff) | (one_strobe & ALU_Out[0]));

    assign Stall = ((state_q == IDLE) & access_vld)
                 | (state_q == ISSUE)
                 | ((state_q == WAIT) & ~mem.mem_done);

    assign load_done = (state_q == WAIT) & mem.mem_done & is_load_q;
    assign mem_out_d = load_done ? mem.mem_rdata : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wdog_q      <= 4'd0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            is_load_q   <= 1'b0;
            mem_out_q   <= 16'h0000;
            alu_out_q   <= 16'h0000;
        end else begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (access_bad) begin
                        err_q <= 1'b1;
                    end
                    if (access_vld && !mem.mem_busy) begin
                        state_q     <= ISSUE;
                        mem_rd_q    <= MemRead_2ff;
                        mem_wr_q    <= MemWrt_2ff;
                        mem_addr_q  <= ALU_Out;
                        mem_wdata_q <= WrData;
                        is_load_q   <= MemRead_2ff;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    wdog_q  <= 4'd0;
                end
                WAIT: begin
                    if (mem.mem_done) begin
                        state_q <= IDLE;
                    end else if (wdog_q == 4'd15) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wdog_q <= wdog_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (!Stall) begin
                alu_out_q <= ALU_Out;
                mem_out_q <= mem_out_d;
            end
        end
    end

    assign mem.mem_rd    = mem_rd_q;
    assign mem.mem_wr    = mem_wr_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign MemOut_ff     = mem_out_q;
    assign ALU_Out_ff    = alu_out_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, busy memory, error cases, watchdog and reset abandonment.
module tb_mem_access_ctrl;
    logic        clk;
    logic        rst;
    logic [15:0] ALU_Out;
    logic [15:0] WrData;
    logic        MemRead_2ff;
    logic        MemWrt_2ff;
    logic        nHaltSig;
    logic        Stall;
    logic [15:0] MemOut_ff;
    logic [15:0] ALU_Out_ff;
    logic        err;

    int n_chk;
    int n_fail;
    int stall_cnt;
    logic err_early;

    mem_access_ctrl_if mif ();

    mem_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ALU_Out     (ALU_Out),
        .WrData      (WrData),
        .MemRead_2ff (MemRead_2ff),
        .MemWrt_2ff  (MemWrt_2ff),
        .nHaltSig    (nHaltSig),
        .mem         (mif),
        .Stall       (Stall),
        .MemOut_ff   (MemOut_ff),
        .ALU_Out_ff  (ALU_Out_ff),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ALU_Out = 16'h5555; WrData = 16'h0; MemRead_2ff = 1'b0; MemWrt_2ff = 1'b0; nHaltSig = 1'b1;
        mif.mem_rdata = 16'h0; mif.mem_done = 1'b0; mif.mem_busy = 1'b0;
        tick(); tick();
        n_chk++; if (MemOut_ff !== 16'h0) begin n_fail++; $display("FAIL reset_memout: got %h expected 0000", MemOut_ff); end
        n_chk++; if (ALU_Out_ff !== 16'h0) begin n_fail++; $display("FAIL reset_aluout: got %h expected 0000", ALU_Out_ff); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_chk++; if (mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rd=%b wr=%b expected 0 0", mif.mem_rd, mif.mem_wr); end
        n_chk++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", Stall); end
        rst = 1'b0;
    endtask

    task automatic test_alu_passthru();
        ALU_Out = 16'h1234; mif.mem_done = 1'b1; mif.mem_rdata = 16'hDEAD;
        #1;
        n_chk++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall: got %b expected 0", Stall); end
        tick();
        mif.mem_done = 1'b0;
        n_chk++; if (ALU_Out_ff !== 16'h1234) begin n_fail++; $display("FAIL alu_ff: got %h expected 1234", ALU_Out_ff); end
        n_chk++; if (MemOut_ff !== 16'h0) begin n_fail++; $display("FAIL idle_done_ignored: got %h expected 0000", MemOut_ff); end
    endtask

    task automatic test_load();
        stall_cnt = 0;
        MemRead_2ff = 1'b1; ALU_Out = 16'h0040; mif.mem_rdata = 16'hBEEF;
        #1;
        if (Stall === 1'b1) stall_cnt++;
        n_chk++; if (mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL load_rd_early: got %b expected 0", mif.mem_rd); end
        tick();
        if (Stall === 1'b1) stall_cnt++;
        n_chk++; if (mif.mem_rd !== 1'b1 || mif.mem_addr !== 16'h0040) begin n_fail++; $display("FAIL load_issue: got rd=%b addr=%h expected 1 0040", mif.mem_rd, mif.mem_addr); end
        tick();
        if (Stall === 1'b1) stall_cnt++;
        n_chk++; if (mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL load_rd_pulse: got %b expected 0", mif.mem_rd); end
        tick();
        if (Stall === 1'b1) stall_cnt++;
        tick();
        mif.mem_done = 1'b1;
        #1;
        if (Stall === 1'b1) stall_cnt++;
        n_chk++; if (stall_cnt != 4) begin n_fail++; $display("FAIL load_stall_cycles: got %0d expected 4", stall_cnt); end
        tick();
        mif.mem_done = 1'b0;
        n_chk++; if (MemOut_ff !== 16'hBEEF) begin n_fail++; $display("FAIL load_data: got %h expected beef", MemOut_ff); end
        n_chk++; if (ALU_Out_ff !== 16'h0040) begin n_fail++; $display("FAIL load_aluff: got %h expected 0040", ALU_Out_ff); end
    endtask

    task automatic test_store();
        MemRead_2ff = 1'b0; MemWrt_2ff = 1'b1; ALU_Out = 16'h0010; WrData = 16'h1234;
        #1;
        n_chk++; if (Stall !== 1'b1 || MemOut_ff !== 16'hBEEF) begin n_fail++; $display("FAIL store_hold: got stall=%b memout=%h expected 1 beef", Stall, MemOut_ff); end
        tick();
        n_chk++; if (mif.mem_wr !== 1'b1 || mif.mem_rd !== 1'b0 || mif.mem_wdata !== 16'h1234 || mif.mem_addr !== 16'h0010) begin
            n_fail++; $display("FAIL store_issue: got wr=%b rd=%b wdata=%h addr=%h expected 1 0 1234 0010", mif.mem_wr, mif.mem_rd, mif.mem_wdata, mif.mem_addr); end
        tick();
        mif.mem_done = 1'b1;
        #1;
        n_chk++; if (Stall !== 1'b0 || mif.mem_wr !== 1'b0) begin n_fail++; $display("FAIL store_done: got stall=%b wr=%b expected 0 0", Stall, mif.mem_wr); end
        tick();
        mif.mem_done = 1'b0; MemWrt_2ff = 1'b0;
        n_chk++; if (MemOut_ff !== 16'h0 || err !== 1'b0 || ALU_Out_ff !== 16'h0010) begin
            n_fail++; $display("FAIL store_result: got memout=%h err=%b alu=%h expected 0000 0 0010", MemOut_ff, err, ALU_Out_ff); end
    endtask

    task automatic test_busy();
        MemRead_2ff = 1'b1; ALU_Out = 16'h0080; mif.mem_busy = 1'b1; mif.mem_rdata = 16'h5A5A;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_chk++; if (Stall !== 1'b1 || mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL busy_hold_%0d: got stall=%b rd=%b expected 1 0", i, Stall, mif.mem_rd); end
            tick();
        end
        mif.mem_busy = 1'b0;
        #1;
        n_chk++; if (Stall !== 1'b1 || mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL busy_release: got stall=%b rd=%b expected 1 0", Stall, mif.mem_rd); end
        tick();
        n_chk++; if (mif.mem_rd !== 1'b1) begin n_fail++; $display("FAIL busy_issue: got %b expected 1", mif.mem_rd); end
        tick();
        mif.mem_done = 1'b1;
        tick();
        mif.mem_done = 1'b0; MemRead_2ff = 1'b0;
        n_chk++; if (MemOut_ff !== 16'h5A5A) begin n_fail++; $display("FAIL busy_data: got %h expected 5a5a", MemOut_ff); end
    endtask

    task automatic test_halt_no_abort();
        MemRead_2ff = 1'b1; ALU_Out = 16'h0100; mif.mem_rdata = 16'h0F0F;
        tick();
        nHaltSig = 1'b0;
        #1;
        n_chk++; if (Stall !== 1'b1 || mif.mem_rd !== 1'b1) begin n_fail++; $display("FAIL halt_issue: got stall=%b rd=%b expected 1 1", Stall, mif.mem_rd); end
        tick();
        n_chk++; if (Stall !== 1'b1) begin n_fail++; $display("FAIL halt_wait: got %b expected 1", Stall); end
        mif.mem_done = 1'b1;
        tick();
        mif.mem_done = 1'b0; MemRead_2ff = 1'b0; nHaltSig = 1'b1;
        n_chk++; if (MemOut_ff !== 16'h0F0F) begin n_fail++; $display("FAIL halt_data: got %h expected 0f0f", MemOut_ff); end
    endtask

    task automatic test_errors();
        MemRead_2ff = 1'b1; ALU_Out = 16'h0003;
        #1;
        n_chk++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL misalign_stall: got %b expected 0", Stall); end
        tick();
        n_chk++; if (err !== 1'b1 || mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL misalign_err: got err=%b rd=%b expected 1 0", err, mif.mem_rd); end
        MemRead_2ff = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        MemRead_2ff = 1'b1; MemWrt_2ff = 1'b1; ALU_Out = 16'h0020; nHaltSig = 1'b0;
        tick();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL halted_conflict_err: got %b expected 0", err); end
        nHaltSig = 1'b1;
        #1;
        n_chk++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL conflict_stall: got %b expected 0", Stall); end
        tick();
        n_chk++; if (err !== 1'b1 || mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0 || ALU_Out_ff !== 16'h0020) begin
            n_fail++; $display("FAIL conflict_err: got err=%b rd=%b wr=%b alu=%h expected 1 0 0 0020", err, mif.mem_rd, mif.mem_wr, ALU_Out_ff); end
        MemRead_2ff = 1'b0; MemWrt_2ff = 1'b0;
        tick(); tick();
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_watchdog();
        rst = 1'b1; tick(); rst = 1'b0;
        MemRead_2ff = 1'b1; ALU_Out = 16'h0200; mif.mem_rdata = 16'hCAFE;
        tick();
        n_chk++; if (mif.mem_rd !== 1'b1) begin n_fail++; $display("FAIL wdog_issue: got %b expected 1", mif.mem_rd); end
        tick();
        MemRead_2ff = 1'b0;
        stall_cnt = 0;
        err_early = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (Stall === 1'b1) stall_cnt++;
            if (err !== 1'b0) err_early = 1'b1;
            tick();
        end
        n_chk++; if (stall_cnt != 16 || err_early !== 1'b0) begin n_fail++; $display("FAIL wdog_wait: got stalls=%0d early_err=%b expected 16 0", stall_cnt, err_early); end
        n_chk++; if (err !== 1'b1 || Stall !== 1'b0) begin n_fail++; $display("FAIL wdog_expire: got err=%b stall=%b expected 1 0", err, Stall); end
        mif.mem_done = 1'b1;
        tick();
        mif.mem_done = 1'b0;
        n_chk++; if (MemOut_ff !== 16'h0 || mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL wdog_late_done: got memout=%h rd=%b expected 0000 0", MemOut_ff, mif.mem_rd); end
    endtask

    task automatic test_reset_mid_wait();
        MemRead_2ff = 1'b1; ALU_Out = 16'h0300; mif.mem_rdata = 16'h7777;
        tick();
        tick();
        MemRead_2ff = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; mif.mem_done = 1'b1;
        #1;
        n_chk++; if (Stall !== 1'b0 || mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0) begin
            n_fail++; $display("FAIL rstwait_idle: got stall=%b rd=%b wr=%b expected 0 0 0", Stall, mif.mem_rd, mif.mem_wr); end
        tick();
        mif.mem_done = 1'b0;
        n_chk++; if (MemOut_ff !== 16'h0 || err !== 1'b0) begin n_fail++; $display("FAIL rstwait_result: got memout=%h err=%b expected 0000 0", MemOut_ff, err); end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        test_reset();
        test_alu_passthru();
        test_load();
        test_store();
        test_busy();
        test_halt_no_abort();
        test_errors();
        test_watchdog();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-002 Port rst, input, 1: reset, synchronous and active-high.
REQ-003 Port ALU_Out, input, 16: execute-stage result; the address for memory accesses.
REQ-004 Port WrData, input, 16: store data forwarded from execute.
REQ-005 Port MemRead_2ff, input, 1: load request from execute.
REQ-006 Port MemWrt_2ff, input, 1: store request from execute.
REQ-007 Port nHaltSig, input, 1: 0 = halt in flight; suppresses any new access.
REQ-008 Ports mem_addr (output, 16) and mem_wdata (output, 16): data-memory address and write data.
REQ-009 Ports mem_rd (output, 1) and mem_wr (output, 1): one-cycle memory request strobes.
REQ-010 Ports mem_rdata (input, 16), mem_done (input, 1) and mem_busy (input, 1): memory read data, completion pulse, and not-ready indication.
REQ-011 Port Stall, output, 1: holds fetch, decode and execute while high.
REQ-012 Port MemOut_ff, output, 16: registered load data to writeback.
REQ-013 Port ALU_Out_ff, output, 16: registered ALU result to writeback.
REQ-014 Port err, output, 1: sticky access-error flag.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE and WAIT, plus a 4-bit watchdog counter.
REQ-016 An access is valid when all of these hold: (MemRead_2ff XOR MemWrt_2ff)=1, nHaltSig=1, ALU_Out[0]=0.
REQ-017 Transitions:
- IDLE: valid access and mem_busy=0 -> ISSUE.
- IDLE: valid access and mem_busy=1 -> stay in IDLE.
REQ-018 In ISSUE, for exactly one cycle:
- mem_rd = MemRead_2ff and mem_wr = MemWrt_2ff.
- mem_addr = ALU_Out and mem_wdata = WrData.
- Next state is WAIT and the watchdog clears to 0.
REQ-019 mem_rd and mem_wr SHALL be 0 in all states other than ISSUE.
REQ-020 WAIT exits:
- mem_done=1 -> IDLE.
- mem_done=0 -> watchdog increments.
- Watchdog=15 with mem_done=0 -> set err, go to IDLE.
REQ-021 Stall SHALL be combinational and high when any of these hold:
- IDLE with a valid access.
- ISSUE.
- WAIT with mem_done=0.
REQ-022 Stall is low otherwise; the mem_done cycle therefore does not stall.
REQ-023 Pipeline registers update only when Stall=0:
- ALU_Out_ff <= ALU_Out.
- MemOut_ff <= mem_rdata if the completing access was a load, else 16'h0000.
REQ-024 Load latency: MemOut_ff holds the data on the clock edge at which mem_done=1 is sampled.
REQ-025 MemRead_2ff and MemWrt_2ff both 1, with nHaltSig=1: set err, issue no access, no Stall, treat as a non-memory op.
REQ-026 Valid strobe with ALU_Out[0]=1 and nHaltSig=1: set err, issue no access, no Stall, treat as a non-memory op.
REQ-027 mem_done arriving in IDLE or ISSUE SHALL be ignored.
REQ-028 err SHALL remain 1 until reset.
REQ-029 nHaltSig=0 SHALL NOT abort an access already in ISSUE or WAIT.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, watchdog=0, MemOut_ff=0, ALU_Out_ff=0, err=0.
REQ-031 Immediately after reset: mem_rd=0, mem_wr=0, and Stall reflects only the current inputs.
REQ-032 Reset during ISSUE or WAIT SHALL abandon the access; a mem_done that arrives afterwards is ignored per REQ-027.

Verification
REQ-033 Load: MemRead_2ff=1, ALU_Out=16'h0040, mem_busy=0, mem_done 3 cycles after mem_rd with mem_rdata=16'hBEEF -> one mem_rd pulse at 16'h0040, Stall high for 4 cycles, then MemOut_ff=16'hBEEF.
REQ-034 Store: MemWrt_2ff=1, ALU_Out=16'h0010, WrData=16'h1234, immediate mem_done after issue -> single mem_wr pulse with mem_wdata=16'h1234, MemOut_ff=0, err=0.
REQ-035 Busy memory: mem_busy=1 for 5 cycles with a load pending -> no mem_rd and Stall high for 5 cycles, then issue on the 6th.
REQ-036 Error cases: ALU_Out=16'h0003 with MemRead_2ff=1 -> err=1, no mem_rd, Stall=0. Both strobes set -> err=1.
REQ-037 Watchdog: load issued, mem_done held 0 -> err=1 and return to IDLE after 16 WAIT cycles; a later mem_done is ignored.
REQ-038 Reset mid-WAIT: rst=1 for one cycle in WAIT, then mem_done=1 -> state IDLE, outputs 0, MemOut_ff unchanged at 0.
